sweep_checker: RTL

Self-checking exhaustive-stimulus engine for small combinational blocks. It drives every value of a WIDTH-bit input vector, in binary or Gray order. Each vector is held for a programmable number of cycles, and the DUT's 1-bit output is sampled and compared against a parameterised truth table. It replaces hand-written per-vector stimulus sequences: it sits beside the DUT in a bench or on-chip self-test wrapper, drives the DUT's input bus, and reports pass/fail with mismatch count and first failing vector.

---
 rtl/sweep_pkg.sv | 30 +++
 rtl/sweep_seq.sv | 83 ++++++++
 rtl/sweep_checker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// ----------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for the exhaustive-sweep checker:
//   - sweep_state_t : controller state encoding (IDLE, RUN, DONE)
//   - MAX_WIDTH     : widest input vector the checker supports
//   - num_vectors() : number of vectors N = 2**width for a given width
//   - gray_enc()    : binary-to-Gray conversion, idx ^ (idx >> 1)
// ----------------------------------------------------------------------------
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int MAX_WIDTH = 10;

    // A WIDTH-bit vector has 2**WIDTH distinct values, all of which are swept.
    function automatic int num_vectors(input int width);
        return 1 << width;
    endfunction

    // Operates at the maximum supported width; callers truncate to their own
    // width, which is safe because Gray bit i only depends on bits i and i+1.
    function automatic logic [MAX_WIDTH-1:0] gray_enc(input logic [MAX_WIDTH-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/sweep_seq.sv
// ----------------------------------------------------------------------------
// sweep_seq
// Vector sequencer: steps an index through 0..N-1, holding each value for
// DWELL cycles, and drives it to the DUT in binary or Gray order.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   load    in   begin a new sweep (clears counters, latches gray)
//   gray    in   order select, captured only on load
//   run     in   sweep in progress; counters advance only while high
//   x       out  registered vector driven to the DUT (0 when not running)
//   sample  out  high in the last dwell cycle of the current vector
//   last    out  current vector is the final one (idx == N-1)
// ----------------------------------------------------------------------------
module sweep_seq
    import sweep_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DWELL = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             gray,
    input  logic             run,
    output logic [WIDTH-1:0] x,
    output logic             sample,
    output logic             last
);

    localparam int N  = num_vectors(WIDTH);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [WIDTH-1:0] IDX_LAST   = WIDTH'(N - 1);

    logic [WIDTH-1:0] idx;
    logic [DW-1:0]    dwell;
    logic             gray_mode;
    logic [WIDTH-1:0] idx_next;
    logic [WIDTH-1:0] x_next;

    // x is registered, so the encoding is computed from the index that is
    // about to become current rather than from the current one.
    assign idx_next = idx + WIDTH'(1);
    assign x_next   = gray_mode ? WIDTH'(gray_enc(MAX_WIDTH'(idx_next))) : idx_next;

    assign sample = run && (dwell == DWELL_LAST);
    assign last   = (idx == IDX_LAST);

    // Index / dwell counters and the driven vector. The first vector is 0 in
    // both orders, so a load can clear x directly. After the final vector is
    // sampled everything returns to 0 so x reads 0 outside a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            dwell     <= '0;
            x         <= '0;
            gray_mode <= 1'b0;
        end else if (load) begin
            idx       <= '0;
            dwell     <= '0;
            x         <= '0;
            gray_mode <= gray;
        end else if (run) begin
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                if (last) begin
                    idx <= '0;
                    x   <= '0;
                end else begin
                    idx <= idx_next;
                    x   <= x_next;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end else begin
            x <= '0;
        end
    end

endmodule

// File: rtl/sweep_checker.sv
// ----------------------------------------------------------------------------
// sweep_checker
// Exhaustive-stimulus engine: drives every WIDTH-bit vector to a DUT, samples
// its 1-bit output at the end of each dwell period and compares it against the
// EXPECT truth table, recording a mismatch count and the first failing vector.
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   start            in   single-cycle sweep request (ignored while busy)
//   gray             in   order select captured with start (1 = Gray)
//   x                out  vector driven to the DUT
//   y                in   DUT output under test
//   busy             out  sweep in progress
//   done             out  sweep complete, results valid
//   err_count        out  number of mismatching vectors
//   first_err_valid  out  at least one mismatch recorded
//   first_err_vec    out  x value of the first mismatch
// ----------------------------------------------------------------------------
module sweep_checker
    import sweep_pkg::*;
#(
    parameter int                        WIDTH  = 3,
    parameter int                        DWELL  = 20,
    parameter logic [(2**WIDTH)-1:0]     EXPECT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gray,
    output logic [WIDTH-1:0] x,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_vec
);

    sweep_state_t state;
    sweep_state_t state_next;

    logic load;
    logic run;
    logic sample;
    logic last;
    logic mismatch;

    // A start is only honoured outside RUN; rst overrides it inside the
    // registers because reset is checked first.
    assign load = start && (state != RUN);
    assign run  = (state == RUN);

    // The truth table is indexed by the applied vector, which differs from
    // the sweep index in Gray mode.
    assign mismatch = sample && (y != EXPECT[x]);

    sweep_seq #(
        .WIDTH (WIDTH),
        .DWELL (DWELL)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .gray   (gray),
        .run    (run),
        .x      (x),
        .sample (sample),
        .last   (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a sweep ends on the sample of the final vector, and
    // DONE may be restarted directly.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)           state_next = RUN;
            RUN:     if (sample && last)  state_next = DONE;
            DONE:    if (start)           state_next = RUN;
            default:                      state_next = IDLE;
        endcase
    end

    // Status outputs decode the state register only, so they never depend
    // combinationally on start or y.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result registers: cleared on every accepted start, accumulated during
    // the sweep and left untouched in DONE until the next start.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (mismatch) begin
            err_count <= err_count + (WIDTH+1)'(1);
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= x;
            end
        end
    end

endmodule
